angle_res_buffer: RTL
=====================

ANGLE_RES_BUFFER -- requirements
Module: angle_res_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of FIFO entries; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter ANGLE_MAX, default 16'd359, giving the largest legal integer quotient.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 val_i  input  1  divider result strobe; one result per high cycle; the source cannot be stalled.
REQ-006 div_res  input  24  divider result: [23:8] unsigned integer quotient, [7:0] unsigned fraction (LSB = 1/256).
REQ-007 angle_valid  output  1  output word is available.
REQ-008 angle_ready  input  1  consumer accepts the output word.
REQ-009 angle_o  output  24  Q16.8 angle, same packing as div_res.
REQ-010 sat_o  output  1  the current output word was clamped; qualified by angle_valid.
REQ-011 ovf_o  output  1  sticky flag: a result was dropped.
REQ-012 level_o  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 Each val_i=1 cycle SHALL be a write request carrying div_res.
REQ-014 Saturation rule:
- If div_res[23:8] > ANGLE_MAX, the stored word SHALL be {ANGLE_MAX, 8'h00} with sat=1.
- Otherwise the stored word SHALL be div_res unchanged with sat=0.
- Saturation is evaluated before storage.
REQ-015 The FIFO SHALL hold {sat, angle} in DEPTH entries using read and write pointers of $clog2(DEPTH)+1 bits; pointers wrap modulo 2*DEPTH.
REQ-016 Output timing:
- The block SHALL be first-word-fall-through.
- angle_o and sat_o SHALL always show the entry at the read pointer.
- angle_valid SHALL equal (level_o != 0).
REQ-017 Latency: a write at rising edge N SHALL make the word visible at the output in the cycle after edge N. There is no same-cycle bypass when the FIFO is empty.
REQ-018 A read SHALL occur on a rising edge where angle_valid=1 and angle_ready=1; the read pointer then advances by one.
REQ-019 A write SHALL be accepted when level_o < DEPTH, or when level_o == DEPTH and a read occurs on the same edge.
REQ-020 A write that is not accepted SHALL be dropped: FIFO contents and pointers are unchanged and ovf_o is set to 1.
REQ-021 Occupancy update on each edge:
- Accepted write with no read: level_o +1.
- Read with no accepted write: level_o -1.
- Both: level_o unchanged.
REQ-022 angle_ready=1 while empty SHALL have no effect, and level_o SHALL never underflow.
REQ-023 Once set, ovf_o SHALL stay at 1 until rst.
REQ-024 Results SHALL leave the block in arrival order, with no duplication and no loss except the drops defined in REQ-020.

Reset
REQ-025 When rst=1 at a rising edge, the next state SHALL be:
- both pointers = 0
- level_o = 0
- angle_valid = 0
- ovf_o = 0
REQ-026 During reset, angle_o and sat_o SHALL be 0, achieved by clearing entry 0 or by masking the outputs.
REQ-027 rst SHALL override val_i and angle_ready on the same edge; any in-flight write or read is discarded.
REQ-028 After rst deasserts, the first val_i SHALL be accepted normally.

Verification
REQ-029 Plain write: val_i=1 with div_res=24'h002D80 (45.5), angle_ready=0 -> next cycle angle_valid=1, angle_o=24'h002D80, sat_o=0, level_o=1.
REQ-030 Saturation: div_res=24'h01F4_40 (500.25) -> angle_o=24'h016700, sat_o=1. Boundary values: 24'h0167FF passes unclamped with sat_o=0; 24'h016800 clamps.
REQ-031 Overflow: with angle_ready=0, send 5 consecutive results 1..5 (DEPTH=4) -> level_o=4, ovf_o=1; draining returns 1,2,3,4, then angle_valid=0.
REQ-032 Full with simultaneous read: FIFO holds 4 entries, val_i=1 and angle_ready=1 on the same edge -> ovf_o stays 0, level_o stays 4, oldest entry popped, new entry is last out.
REQ-033 Reset mid-operation: level_o=3 and ovf_o=1, then rst=1 for one cycle while val_i=1 -> level_o=0, angle_valid=0, ovf_o=0; the next val_i is output first.
REQ-034 Random stress: random val_i at 50% and random angle_ready -> the scoreboard shows in-order delivery, and every dropped word coincides with level_o==DEPTH and no read on that edge.

Source files
------------

// File: rtl/angle_res_buffer.sv
// Angle result buffer: clamps divider quotients to ANGLE_MAX and queues
// them in a first-word-fall-through FIFO with a sticky overflow flag.
module angle_res_buffer #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] ANGLE_MAX = 16'd359
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       val_i,
  input  logic [23:0]                div_res,
  output logic                       angle_valid,
  input  logic                       angle_ready,
  output logic [23:0]                angle_o,
  output logic                       sat_o,
  output logic                       ovf_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(DEPTH);

  logic [24:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          ovf_q;

  logic          full;
  logic          rd_en;
  logic          wr_en;
  logic          sat_in;
  logic [23:0]   word_in;
  logic [24:0]   rd_word;

  assign level_o     = wr_ptr - rd_ptr;
  assign full        = (level_o == FULL_LVL);
  assign angle_valid = (level_o != '0);
  assign rd_en       = angle_valid && angle_ready;
  assign wr_en       = val_i && (!full || rd_en);

  always_comb begin
    sat_in  = 1'b0;
    word_in = div_res;
    if (div_res[23:8] > ANGLE_MAX) begin
      sat_in  = 1'b1;
      word_in = {ANGLE_MAX, 8'h00};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf_q  <= 1'b0;
      mem[0] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= {sat_in, word_in};
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (rd_en)
        rd_ptr <= rd_ptr + 1'b1;
      if (val_i && !wr_en)
        ovf_q <= 1'b1;
    end
  end

  // Masked during reset so stale entry-0 data never shows.
  assign rd_word = rst ? '0 : mem[rd_ptr[AW-1:0]];
  assign angle_o = rd_word[23:0];
  assign sat_o   = rd_word[24];
  assign ovf_o   = ovf_q;

endmodule
